core_id_iqueue: RTL and testbench
=================================

Name: core_id_iqueue

Overview:
- Parametrised decode-stage front end that replaces the single-entry ID pipeline register with a DEPTH-entry instruction queue.
- Performs RAW hazard detection against NUM_FWD downstream producer stages.
- Selects a per-operand forwarding source where the producing stage can bypass, and stalls only where it cannot.
- Sits between the IF stage and the decoder/EXU; its head entry feeds the decoder and the regfile read ports.

Parameters:
- DEPTH, 4, queue entries; power of 2, >= 2
- PC_W, 32, PC width
- INST_W, 32, instruction width
- RFIDX_W, 5, register index width
- NUM_FWD, 2, number of producer stages checked; index 0 is the youngest (EX)
- FWD_MASK, 2'b10, bit i = 1 means stage i can forward its result; 0 means a match stalls

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_in  in  1  IF entry valid
- ready_in  out  1  queue can accept
- i_pc  in  PC_W  fetched PC
- i_inst  in  INST_W  fetched instruction
- i_branch_predict  in  1  predicted-taken flag
- valid_out  out  1  head entry issuable
- ready_out  in  1  downstream accepts head
- o_pc  out  PC_W  head PC
- o_inst  out  INST_W  head instruction
- o_branch_predict  out  1  head prediction flag
- o_rs1_idx, o_rs2_idx  out  RFIDX_W  inst[19:15], inst[24:20] of head
- o_rs1_ren, o_rs2_ren  out  1  operand-used flags
- o_rs1_fwd, o_rs2_fwd  out  NUM_FWD  one-hot forward select; all-zero selects the regfile
- fwd_rd_idx  in  NUM_FWD*RFIDX_W  packed destination index per stage
- fwd_rd_wen  in  NUM_FWD  stage writes rd
- fwd_valid  in  NUM_FWD  stage holds a live instruction
- i_pipe_flush_req  in  1  flush request
- o_count  out  $clog2(DEPTH)+1  occupancy
- o_hazard_stall  out  1  head blocked by a RAW hazard

Behaviour:
- Reset (rst=1 at a clk edge): pointers and count cleared to 0.
  - Result: valid_out=0, ready_in=1, o_hazard_stall=0, o_count=0.
  - Storage RAM is not reset. Head outputs are don't-care while empty and are driven from entry 0.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits each; the extra bit is the wrap flag.
  - full = (MSBs differ and low bits equal); empty = (pointers equal).
  - o_count = wr_ptr - rd_ptr, modulo 2^($clog2(DEPTH)+1).
- Push = valid_in & ready_in.
  - ready_in = ~full, purely registered state; no combinational dependence on ready_out.
  - Push and pop in the same cycle are legal at any non-full occupancy; the count is unchanged.
  - When full, a pop frees a slot only on the following cycle.
- Pop = valid_out & ready_out. The head advances one entry per pop. Throughput is 1/cycle when there is no hazard.
- Operand-use decode is done on the head's opcode, inst[6:0]:
  - rs1_ren = 0 for LUI 0110111, AUIPC 0010111, JAL 1101111; 1 otherwise.
  - rs2_ren = 1 only for BRANCH 1100011, STORE 0100011, OP 0110011.
- Hazard match, per operand r and stage i: m[i] = ren_r & fwd_valid[i] & fwd_rd_wen[i] & (fwd_rd_idx[i] == idx_r) & (idx_r != 0).
- Priority: the lowest-index matching stage wins.
  - If that stage has FWD_MASK[i] = 1, then o_rX_fwd = one-hot(i).
  - If FWD_MASK[i] = 0, the operand stalls. Older matches are ignored because the youngest holds the newest value.
  - o_rX_fwd is all-zero if there is no match or if the operand stalls.
- o_hazard_stall = rs1 stall | rs2 stall, gated by ~empty.
- valid_out = ~empty & ~o_hazard_stall & ~i_pipe_flush_req.
- Flush:
  - In the cycle where i_pipe_flush_req=1: valid_out is forced 0 and any push that cycle is discarded.
  - At the next edge: rd_ptr <= wr_ptr, and the queue becomes empty, so o_count=0 next cycle.
  - A flush takes priority over a simultaneous push and pop.
  - Flush and reset asserted together: reset wins, same end state.
- Latency: an instruction pushed at edge N appears at the head in cycle N+1 if the queue was empty, i.e. one cycle, the same as the previous single-register stage.
- The head outputs must remain stable while valid_out=1 & ready_out=0.

Test Plan:
- Reset, then push 4 instructions (PC 0x0,0x4,0x8,0xC) with ready_out=0 → o_count=4, ready_in=0, o_pc=0x0; then a 5th valid_in is not accepted.
- From the full state, hold valid_in and ready_out high → one pop per cycle, PCs in order 0x0..0xC, no entry lost or duplicated across the pointer wrap; o_count steady at DEPTH-1/DEPTH after the first cycle.
- Head ADD x3,x1,x2, with stage0 wen=1 idx=1 valid=1 (FWD_MASK[0]=0) → o_hazard_stall=1, valid_out=0; drop stage0 valid → valid_out=1 next comb, o_rs1_fwd=00.
- Head ADD x3,x1,x2, with stage1 idx=2 wen=1 valid=1 (FWD_MASK[1]=1) → valid_out=1, o_rs2_fwd=2'b10, o_rs1_fwd=2'b00.
- Head LUI x5 with stage0 idx=0 or any rs1 match → no stall (rs1_ren=0); ADD with rs1=x0 and stage0 idx=0 wen=1 → no stall.
- Queue holds 3 entries; pulse i_pipe_flush_req together with valid_in=1 → valid_out=0 that cycle, o_count=0 next cycle, flushed push absent; the next push appears at the head after 1 cycle.

Source files
------------

// File: rtl/core_id_iqueue_if.sv
// Fetch-to-queue push bus and queue-to-decoder issue bus for the decode-stage instruction queue.
interface core_id_iqueue_if #(
    parameter int PC_W    = 32,
    parameter int INST_W  = 32,
    parameter int RFIDX_W = 5,
    parameter int NUM_FWD = 2
);
    logic               valid_in;
    logic               ready_in;
    logic [PC_W-1:0]    i_pc;
    logic [INST_W-1:0]  i_inst;
    logic               i_branch_predict;

    logic               valid_out;
    logic               ready_out;
    logic [PC_W-1:0]    o_pc;
    logic [INST_W-1:0]  o_inst;
    logic               o_branch_predict;
    logic [RFIDX_W-1:0] o_rs1_idx;
    logic [RFIDX_W-1:0] o_rs2_idx;
    logic               o_rs1_ren;
    logic               o_rs2_ren;
    logic [NUM_FWD-1:0] o_rs1_fwd;
    logic [NUM_FWD-1:0] o_rs2_fwd;

    modport master (
        output valid_in, i_pc, i_inst, i_branch_predict, ready_out,
        input  ready_in, valid_out, o_pc, o_inst, o_branch_predict,
        input  o_rs1_idx, o_rs2_idx, o_rs1_ren, o_rs2_ren, o_rs1_fwd, o_rs2_fwd
    );

    modport slave (
        input  valid_in, i_pc, i_inst, i_branch_predict, ready_out,
        output ready_in, valid_out, o_pc, o_inst, o_branch_predict,
        output o_rs1_idx, o_rs2_idx, o_rs1_ren, o_rs2_ren, o_rs1_fwd, o_rs2_fwd
    );
endinterface

// File: rtl/core_id_iqueue.sv
// Decode-stage instruction queue: DEPTH-entry FIFO whose head feeds the decoder, with RAW
// hazard detection and per-operand forwarding selection against NUM_FWD producer stages.
module core_id_iqueue #(
    parameter int                 DEPTH    = 4,
    parameter int                 PC_W     = 32,
    parameter int                 INST_W   = 32,
    parameter int                 RFIDX_W  = 5,
    parameter int                 NUM_FWD  = 2,
    parameter logic [NUM_FWD-1:0] FWD_MASK = 2'b10
) (
    input  logic                         clk,
    input  logic                         rst,
    core_id_iqueue_if.slave              io_q,
    input  logic [NUM_FWD*RFIDX_W-1:0]   fwd_rd_idx,
    input  logic [NUM_FWD-1:0]           fwd_rd_wen,
    input  logic [NUM_FWD-1:0]           fwd_valid,
    input  logic                         i_pipe_flush_req,
    output logic [$clog2(DEPTH):0]       o_count,
    output logic                         o_hazard_stall
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [PC_W-1:0]    r_mem_pc   [DEPTH];
    logic [INST_W-1:0]  r_mem_inst [DEPTH];
    logic               r_mem_bp   [DEPTH];

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [INST_W-1:0]  w_head_inst;
    logic [6:0]         w_opcode;
    logic [RFIDX_W-1:0] w_rs1_idx;
    logic [RFIDX_W-1:0] w_rs2_idx;
    logic               w_rs1_ren;
    logic               w_rs2_ren;
    logic [NUM_FWD-1:0] w_rs1_fwd;
    logic [NUM_FWD-1:0] w_rs2_fwd;
    logic               w_rs1_stall;
    logic               w_rs2_stall;
    logic               w_rs1_hit;
    logic               w_rs2_hit;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;

    assign io_q.ready_in = ~w_full;
    assign w_push        = io_q.valid_in & ~w_full & ~i_pipe_flush_req;
    assign w_pop         = io_q.valid_out & io_q.ready_out;

    // The head slot is never overwritten while occupied, so head outputs hold steady under backpressure.
    assign w_head_inst           = r_mem_inst[r_rd_ptr[AW-1:0]];
    assign io_q.o_pc             = r_mem_pc[r_rd_ptr[AW-1:0]];
    assign io_q.o_inst           = w_head_inst;
    assign io_q.o_branch_predict = r_mem_bp[r_rd_ptr[AW-1:0]];

    assign w_opcode  = w_head_inst[6:0];
    assign w_rs1_idx = w_head_inst[19:15];
    assign w_rs2_idx = w_head_inst[24:20];
    assign w_rs1_ren = (w_opcode != OPC_LUI) && (w_opcode != OPC_AUIPC) && (w_opcode != OPC_JAL);
    assign w_rs2_ren = (w_opcode == OPC_BRANCH) || (w_opcode == OPC_STORE) || (w_opcode == OPC_OP);

    // Only the youngest matching producer matters; it either bypasses or stalls the operand.
    always_comb begin
        w_rs1_fwd   = '0;
        w_rs2_fwd   = '0;
        w_rs1_stall = 1'b0;
        w_rs2_stall = 1'b0;
        w_rs1_hit   = 1'b0;
        w_rs2_hit   = 1'b0;
        for (int i = 0; i < NUM_FWD; i++) begin
            if (!w_rs1_hit && w_rs1_ren && fwd_valid[i] && fwd_rd_wen[i] &&
                (fwd_rd_idx[i*RFIDX_W +: RFIDX_W] == w_rs1_idx) && (w_rs1_idx != '0)) begin
                w_rs1_hit = 1'b1;
                if (FWD_MASK[i]) w_rs1_fwd[i] = 1'b1;
                else             w_rs1_stall  = 1'b1;
            end
            if (!w_rs2_hit && w_rs2_ren && fwd_valid[i] && fwd_rd_wen[i] &&
                (fwd_rd_idx[i*RFIDX_W +: RFIDX_W] == w_rs2_idx) && (w_rs2_idx != '0)) begin
                w_rs2_hit = 1'b1;
                if (FWD_MASK[i]) w_rs2_fwd[i] = 1'b1;
                else             w_rs2_stall  = 1'b1;
            end
        end
    end

    assign io_q.o_rs1_idx = w_rs1_idx;
    assign io_q.o_rs2_idx = w_rs2_idx;
    assign io_q.o_rs1_ren = w_rs1_ren;
    assign io_q.o_rs2_ren = w_rs2_ren;
    assign io_q.o_rs1_fwd = w_rs1_fwd;
    assign io_q.o_rs2_fwd = w_rs2_fwd;

    assign o_hazard_stall = ~w_empty & (w_rs1_stall | w_rs2_stall);
    assign io_q.valid_out = ~w_empty & ~o_hazard_stall & ~i_pipe_flush_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_pipe_flush_req) begin
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr[AW-1:0]]   <= io_q.i_pc;
            r_mem_inst[r_wr_ptr[AW-1:0]] <= io_q.i_inst;
            r_mem_bp[r_wr_ptr[AW-1:0]]   <= io_q.i_branch_predict;
        end
    end
endmodule

// File: tb/tb_core_id_iqueue.sv
// Self-checking bench for core_id_iqueue: a negedge monitor scoreboards every accepted push
// against every issued head entry, while scenario tasks check occupancy, hazards and forwarding.
module tb_core_id_iqueue;
    localparam int DEPTH   = 4;
    localparam int PC_W    = 32;
    localparam int INST_W  = 32;
    localparam int RFIDX_W = 5;
    localparam int NUM_FWD = 2;
    localparam logic [6:0] OPC_OP = 7'b0110011;

    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic              bp;
    } entry_t;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_FWD*RFIDX_W-1:0] fwd_rd_idx;
    logic [NUM_FWD-1:0]         fwd_rd_wen;
    logic [NUM_FWD-1:0]         fwd_valid;
    logic                       flush;
    logic [$clog2(DEPTH):0]     o_count;
    logic                       o_hazard_stall;

    int     checks = 0;
    int     errors = 0;
    entry_t sb[$];
    entry_t exp_e;

    core_id_iqueue_if #(.PC_W(PC_W), .INST_W(INST_W), .RFIDX_W(RFIDX_W), .NUM_FWD(NUM_FWD)) q_if ();

    core_id_iqueue #(
        .DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W), .RFIDX_W(RFIDX_W),
        .NUM_FWD(NUM_FWD), .FWD_MASK(2'b10)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .io_q             (q_if),
        .fwd_rd_idx       (fwd_rd_idx),
        .fwd_rd_wen       (fwd_rd_wen),
        .fwd_valid        (fwd_valid),
        .i_pipe_flush_req (flush),
        .o_count          (o_count),
        .o_hazard_stall   (o_hazard_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scoreboard: record accepted pushes, compare each issued head in order; flush/reset drop everything.
    always @(negedge clk) begin
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (q_if.valid_out && q_if.ready_out) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL sb_pop: issued pc=%h with nothing outstanding, required no issue", q_if.o_pc);
                end else begin
                    exp_e = sb.pop_front();
                    if (q_if.o_pc !== exp_e.pc || q_if.o_inst !== exp_e.inst || q_if.o_branch_predict !== exp_e.bp) begin
                        errors++;
                        $display("[TB] FAIL sb_pop: got pc=%h inst=%h bp=%b, required pc=%h inst=%h bp=%b",
                                 q_if.o_pc, q_if.o_inst, q_if.o_branch_predict, exp_e.pc, exp_e.inst, exp_e.bp);
                    end
                end
            end
            if (q_if.valid_in && q_if.ready_in)
                sb.push_back('{pc: q_if.i_pc, inst: q_if.i_inst, bp: q_if.i_branch_predict});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [INST_W-1:0] mk_op(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, OPC_OP};
    endfunction

    task automatic test_reset();
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (o_count !== 3'd0) begin errors++; $display("[TB] FAIL rst_count: got %0d required 0", o_count); end
        checks++; if (q_if.valid_out !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid_out: got %b required 0", q_if.valid_out); end
        checks++; if (q_if.ready_in !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready_in: got %b required 1", q_if.ready_in); end
        checks++; if (o_hazard_stall !== 1'b0) begin errors++; $display("[TB] FAIL rst_stall: got %b required 0", o_hazard_stall); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (o_count !== 3'd0) begin errors++; $display("[TB] FAIL rst_release_count: got %0d required 0", o_count); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            q_if.ready_out        = 1'b0;
            q_if.valid_in         = 1'b1;
            q_if.i_pc             = 32'(i * 4);
            q_if.i_inst           = {12'(i + 1), 5'd0, 3'b000, 5'd1, 7'b0010011};
            q_if.i_branch_predict = i[0];
        end
        tick();
        q_if.i_pc   = 32'h10;
        q_if.i_inst = {12'h0AA, 5'd0, 3'b000, 5'd2, 7'b0010011};
        @(negedge clk);
        checks++; if (o_count !== 3'd4) begin errors++; $display("[TB] FAIL fill_count: got %0d required 4", o_count); end
        checks++; if (q_if.ready_in !== 1'b0) begin errors++; $display("[TB] FAIL fill_ready_in: got %b required 0", q_if.ready_in); end
        checks++; if (q_if.o_pc !== 32'h0) begin errors++; $display("[TB] FAIL fill_head_pc: got %h required 0", q_if.o_pc); end
        checks++; if (q_if.valid_out !== 1'b1) begin errors++; $display("[TB] FAIL fill_valid_out: got %b required 1", q_if.valid_out); end
        tick();
        @(negedge clk);
        checks++; if (o_count !== 3'd4) begin errors++; $display("[TB] FAIL fill_fifth_rejected: got %0d required 4", o_count); end
        checks++; if (q_if.o_pc !== 32'h0) begin errors++; $display("[TB] FAIL fill_head_stable: got %h required 0", q_if.o_pc); end
    endtask

    task automatic test_back_to_back();
        bit done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            q_if.ready_out        = 1'b1;
            q_if.valid_in         = 1'b1;
            q_if.i_pc             = 32'h10 + 32'(c * 4);
            q_if.i_inst           = {12'(c + 16), 5'd0, 3'b000, 5'd3, 7'b0010011};
            q_if.i_branch_predict = c[1];
            @(negedge clk);
            checks++;
            if (o_count !== ((c == 0) ? 3'd4 : 3'd3)) begin
                errors++; $display("[TB] FAIL stream_count c=%0d: got %0d required %0d", c, o_count, (c == 0) ? 4 : 3);
            end
            checks++;
            if (q_if.valid_out !== 1'b1) begin errors++; $display("[TB] FAIL stream_valid c=%0d: got %b required 1", c, q_if.valid_out); end
        end
        tick();
        q_if.valid_in = 1'b0;
        for (int n = 0; n < 16 && !done; n++) begin
            @(negedge clk);
            if (o_count == 3'd0) done = 1'b1;
            else @(posedge clk);
        end
        checks++; if (!done) begin errors++; $display("[TB] FAIL stream_drain: count=%0d after cycle budget, required 0", o_count); end
        checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL stream_sb_empty: %0d outstanding, required 0", sb.size()); end
        checks++; if (q_if.valid_out !== 1'b0) begin errors++; $display("[TB] FAIL stream_empty_valid: got %b required 0", q_if.valid_out); end
        tick();
        q_if.ready_out = 1'b0;
    endtask

    task automatic test_hazard_fwd();
        tick();
        q_if.valid_in = 1'b1; q_if.i_pc = 32'h200; q_if.i_inst = mk_op(5'd3, 5'd1, 5'd2); q_if.i_branch_predict = 1'b0;
        fwd_valid = 2'b01; fwd_rd_wen = 2'b01; fwd_rd_idx = {5'd0, 5'd1};
        tick();
        q_if.valid_in = 1'b0;
        @(negedge clk);
        checks++; if (o_hazard_stall !== 1'b1) begin errors++; $display("[TB] FAIL hz_ex_stall: got %b required 1", o_hazard_stall); end
        checks++; if (q_if.valid_out !== 1'b0) begin errors++; $display("[TB] FAIL hz_ex_valid: got %b required 0", q_if.valid_out); end
        checks++; if (q_if.o_rs1_idx !== 5'd1 || q_if.o_rs2_idx !== 5'd2) begin
            errors++; $display("[TB] FAIL hz_idx: got rs1=%0d rs2=%0d required 1 2", q_if.o_rs1_idx, q_if.o_rs2_idx); end
        tick();
        fwd_valid = 2'b00;
        @(negedge clk);
        checks++; if (q_if.valid_out !== 1'b1) begin errors++; $display("[TB] FAIL hz_clear_valid: got %b required 1", q_if.valid_out); end
        checks++; if (q_if.o_rs1_fwd !== 2'b00) begin errors++; $display("[TB] FAIL hz_clear_fwd: got %b required 00", q_if.o_rs1_fwd); end
        tick();
        fwd_valid = 2'b01; fwd_rd_wen = 2'b00; fwd_rd_idx = {5'd0, 5'd1};
        @(negedge clk);
        checks++; if (q_if.valid_out !== 1'b1) begin errors++; $display("[TB] FAIL hz_nowen_valid: got %b required 1", q_if.valid_out); end
        tick();
        fwd_valid = 2'b10; fwd_rd_wen = 2'b10; fwd_rd_idx = {5'd2, 5'd0};
        @(negedge clk);
        checks++; if (q_if.valid_out !== 1'b1) begin errors++; $display("[TB] FAIL fwd_rs2_valid: got %b required 1", q_if.valid_out); end
        checks++; if (q_if.o_rs2_fwd !== 2'b10) begin errors++; $display("[TB] FAIL fwd_rs2_sel: got %b required 10", q_if.o_rs2_fwd); end
        checks++; if (q_if.o_rs1_fwd !== 2'b00) begin errors++; $display("[TB] FAIL fwd_rs1_none: got %b required 00", q_if.o_rs1_fwd); end
        tick();
        fwd_valid = 2'b11; fwd_rd_wen = 2'b11; fwd_rd_idx = {5'd2, 5'd2};
        @(negedge clk);
        checks++; if (o_hazard_stall !== 1'b1) begin errors++; $display("[TB] FAIL prio_stall: got %b required 1", o_hazard_stall); end
        checks++; if (q_if.o_rs2_fwd !== 2'b00) begin errors++; $display("[TB] FAIL prio_fwd: got %b required 00", q_if.o_rs2_fwd); end
        tick();
        fwd_valid = 2'b10; fwd_rd_wen = 2'b10; fwd_rd_idx = {5'd1, 5'd0};
        @(negedge clk);
        checks++; if (q_if.o_rs1_fwd !== 2'b10 || q_if.o_rs2_fwd !== 2'b00) begin
            errors++; $display("[TB] FAIL fwd_rs1_sel: got rs1=%b rs2=%b required 10 00", q_if.o_rs1_fwd, q_if.o_rs2_fwd); end
        tick();
        fwd_valid = 2'b00; q_if.ready_out = 1'b1;
        @(negedge clk);
        checks++; if (q_if.valid_out !== 1'b1) begin errors++; $display("[TB] FAIL hz_pop_valid: got %b required 1", q_if.valid_out); end
        tick();
        q_if.ready_out = 1'b0;
    endtask

    task automatic test_x0_lui();
        logic [INST_W-1:0] lui = {20'h12345, 5'd5, 7'b0110111};
        tick();
        q_if.valid_in = 1'b1; q_if.i_pc = 32'h400; q_if.i_inst = lui; q_if.i_branch_predict = 1'b1;
        fwd_valid = 2'b01; fwd_rd_wen = 2'b01; fwd_rd_idx = {5'd0, lui[19:15]};
        tick();
        q_if.valid_in = 1'b0;
        @(negedge clk);
        checks++; if (q_if.valid_out !== 1'b1 || o_hazard_stall !== 1'b0) begin
            errors++; $display("[TB] FAIL lui_nostall: got valid=%b stall=%b required 1 0", q_if.valid_out, o_hazard_stall); end
        checks++; if (q_if.o_rs1_ren !== 1'b0 || q_if.o_rs2_ren !== 1'b0) begin
            errors++; $display("[TB] FAIL lui_ren: got %b%b required 00", q_if.o_rs1_ren, q_if.o_rs2_ren); end
        tick();
        q_if.ready_out = 1'b1;
        tick();
        q_if.ready_out = 1'b0;
        q_if.valid_in = 1'b1; q_if.i_pc = 32'h404; q_if.i_inst = mk_op(5'd3, 5'd0, 5'd2); q_if.i_branch_predict = 1'b0;
        fwd_valid = 2'b01; fwd_rd_wen = 2'b01; fwd_rd_idx = {5'd0, 5'd0};
        tick();
        q_if.valid_in = 1'b0;
        @(negedge clk);
        checks++; if (q_if.valid_out !== 1'b1 || o_hazard_stall !== 1'b0) begin
            errors++; $display("[TB] FAIL x0_nostall: got valid=%b stall=%b required 1 0", q_if.valid_out, o_hazard_stall); end
        checks++; if (q_if.o_rs1_ren !== 1'b1 || q_if.o_rs2_ren !== 1'b1 || q_if.o_rs1_fwd !== 2'b00) begin
            errors++; $display("[TB] FAIL x0_ren_fwd: got ren=%b%b fwd=%b required 11 00", q_if.o_rs1_ren, q_if.o_rs2_ren, q_if.o_rs1_fwd); end
        tick();
        q_if.ready_out = 1'b1; fwd_valid = 2'b00;
        tick();
        q_if.ready_out = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            tick();
            q_if.valid_in = 1'b1; q_if.i_pc = 32'h500 + 32'(i * 4);
            q_if.i_inst = mk_op(5'(i + 4), 5'd6, 5'd7); q_if.i_branch_predict = 1'b0;
        end
        tick();
        flush = 1'b1; q_if.i_pc = 32'hDEAD0; q_if.i_inst = mk_op(5'd9, 5'd9, 5'd9);
        @(negedge clk);
        checks++; if (o_count !== 3'd3) begin errors++; $display("[TB] FAIL flush_pre_count: got %0d required 3", o_count); end
        checks++; if (q_if.valid_out !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid_out: got %b required 0", q_if.valid_out); end
        tick();
        flush = 1'b0; q_if.i_pc = 32'h300; q_if.i_inst = mk_op(5'd10, 5'd11, 5'd12); q_if.i_branch_predict = 1'b1;
        @(negedge clk);
        checks++; if (o_count !== 3'd0) begin errors++; $display("[TB] FAIL flush_count: got %0d required 0", o_count); end
        checks++; if (q_if.valid_out !== 1'b0) begin errors++; $display("[TB] FAIL flush_empty_valid: got %b required 0", q_if.valid_out); end
        tick();
        q_if.valid_in = 1'b0;
        @(negedge clk);
        checks++; if (o_count !== 3'd1) begin errors++; $display("[TB] FAIL flush_next_count: got %0d required 1", o_count); end
        checks++; if (q_if.valid_out !== 1'b1 || q_if.o_pc !== 32'h300) begin
            errors++; $display("[TB] FAIL flush_next_head: got valid=%b pc=%h required 1 300", q_if.valid_out, q_if.o_pc); end
        tick();
        q_if.ready_out = 1'b1;
        tick();
        q_if.ready_out = 1'b0;
        @(negedge clk);
        checks++; if (o_count !== 3'd0) begin errors++; $display("[TB] FAIL flush_final_count: got %0d required 0", o_count); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        fwd_rd_idx = '0; fwd_rd_wen = '0; fwd_valid = '0;
        q_if.valid_in = 1'b0; q_if.ready_out = 1'b0;
        q_if.i_pc = '0; q_if.i_inst = '0; q_if.i_branch_predict = 1'b0;
        test_reset();
        test_fill();
        test_back_to_back();
        test_hazard_fwd();
        test_x0_lui();
        test_flush();
        @(negedge clk);
        checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL end_sb_empty: %0d outstanding, required 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
